aclk_keypad_scanner: RTL and testbench

//  Upstream front end of the alarm clock. Scans a 4x3 matrix keypad, rejects ghosted multi-key presses and

---
 rtl/aclk_defs.sv | 51 +++++
 rtl/aclk_row_scanner.sv | 65 ++++++
 rtl/aclk_keypad_scanner.sv | 130 +++++++++++++
 tb/tb_aclk_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_defs.sv
// Shared constants, key codes and FSM state encoding for the alarm-clock keypad front end.
package aclk_defs;

    localparam int ROWS = 4;
    localparam int COLS = 3;

    localparam logic [3:0] NOKEY    = 4'hA;
    localparam logic [3:0] KEY_STAR = 4'hB;
    localparam logic [3:0] KEY_HASH = 4'hC;

    // Key code for each switch, indexed [row][col], columns left to right.
    localparam logic [3:0] KEYMAP [ROWS][COLS] = '{
        '{4'd1,     4'd2, 4'd3    },
        '{4'd4,     4'd5, 4'd6    },
        '{4'd7,     4'd8, 4'd9    },
        '{KEY_STAR, 4'd0, KEY_HASH}
    };

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    typedef struct packed {
        logic [3:0] key;
        logic       time_button;
        logic       alarm_button;
    } key_out_t;

    // Number of active-low columns in one row sample (0..3).
    function automatic logic [1:0] count_low(input logic [COLS-1:0] col_n);
        logic [1:0] n;
        n = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_n[c]) n = n + 2'd1;
        end
        return n;
    endfunction

    // Maps an accepted key code onto the three level outputs.
    function automatic key_out_t decode_outputs(input logic [3:0] code);
        key_out_t o;
        o.key          = (code < 4'd10) ? code : NOKEY;
        o.time_button  = (code == KEY_STAR);
        o.alarm_button = (code == KEY_HASH);
        return o;
    endfunction

endpackage

// File: rtl/aclk_row_scanner.sv
// Walks a low on each keypad row, samples the columns at the end of each dwell and
// reports a ghost-rejected single-key code once per full scan.
module aclk_row_scanner
    import aclk_defs::*;
#(
    parameter int SCAN_DIV = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic       scan_done,
    output logic [3:0] scan_result
);

    localparam int              DW         = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0]   LAST_DWELL = DW'(SCAN_DIV - 1);

    logic [DW-1:0] dwell;
    logic [1:0]    row;
    logic          sample;

    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [1:0]    acc_hits_next;
    logic [3:0]    acc_code_next;
    logic [1:0]    row_hits;
    logic [3:0]    row_code;
    logic [2:0]    total_hits;

    assign sample    = (dwell == LAST_DWELL);
    assign scan_done = sample && (row == 2'd3);
    assign row_n     = ~(4'b0001 << row);

    // NOTE: sequential state uses non-blocking assignments only; the comb block below uses blocking.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell    <= '0;
            row      <= '0;
            acc_hits <= '0;
            acc_code <= NOKEY;
        end else if (sample) begin
            dwell    <= '0;
            row      <= row + 2'd1;
            acc_hits <= scan_done ? 2'd0 : acc_hits_next;
            acc_code <= scan_done ? NOKEY : acc_code_next;
        end else begin
            dwell    <= dwell + DW'(1);
        end
    end

    // Hit count saturates at 2: anything beyond one key is a ghost-rejected scan.
    always_comb begin
        row_hits = count_low(col_n);
        row_code = NOKEY;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_n[c]) row_code = KEYMAP[row][c];
        end
        total_hits    = 3'(acc_hits) + 3'(row_hits);
        acc_hits_next = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
        acc_code_next = (acc_hits == 2'd0) ? row_code : acc_code;
        scan_result   = (total_hits == 3'd1) ? acc_code_next : NOKEY;
    end

endmodule

// File: rtl/aclk_keypad_scanner.sv
// Keypad front end: row scanner plus a scan-rate debounce FSM driving registered
// key / time_button / alarm_button levels and a one-cycle key_press pulse.
module aclk_keypad_scanner
    import aclk_defs::*;
#(
    parameter int SCAN_DIV       = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       time_button,
    output logic       alarm_button,
    output logic       key_press
);

    localparam logic [3:0] DB_MAX  = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cand;
    logic [3:0] cand_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       press_next;
    key_out_t   out_next;

    logic       scan_done;
    logic [3:0] scan_result;

    // scan_done/scan_result are combinational, so the FSM and outputs load on the scan-end edge.
    aclk_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clock       (clock),
        .reset       (reset),
        .col_n       (col_n),
        .row_n       (row_n),
        .scan_done   (scan_done),
        .scan_result (scan_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cand         <= NOKEY;
            cnt          <= '0;
            key          <= NOKEY;
            time_button  <= 1'b0;
            alarm_button <= 1'b0;
            key_press    <= 1'b0;
        end else begin
            state        <= state_next;
            cand         <= cand_next;
            cnt          <= cnt_next;
            key          <= out_next.key;
            time_button  <= out_next.time_button;
            alarm_button <= out_next.alarm_button;
            key_press    <= press_next;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        press_next = 1'b0;

        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_result != NOKEY) begin
                        state_next = PRESS_CHK;
                        cand_next  = scan_result;
                        cnt_next   = 4'd1;
                    end
                end
                PRESS_CHK: begin
                    if (scan_result == cand) begin
                        if (cnt >= DB_LAST) begin
                            state_next = HELD;
                            cnt_next   = DB_MAX;
                            press_next = 1'b1;
                        end else begin
                            cnt_next   = cnt + 4'd1;
                        end
                    end else if (scan_result == NOKEY) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cand_next  = scan_result;
                        cnt_next   = 4'd1;
                    end
                end
                HELD: begin
                    if (scan_result != cand) begin
                        state_next = RELEASE_CHK;
                        cnt_next   = 4'd1;
                    end
                end
                RELEASE_CHK: begin
                    // A returning key is a glitch: back to HELD with no new press pulse.
                    if (scan_result == cand) begin
                        state_next = HELD;
                        cnt_next   = DB_MAX;
                    end else if (cnt >= DB_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt + 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        out_next = decode_outputs(NOKEY);
        if (state_next == HELD || state_next == RELEASE_CHK) begin
            out_next = decode_outputs(cand_next);
        end
    end

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Scoreboard bench for aclk_keypad_scanner: stimulus queues expected output changes,
// a negedge monitor pops and compares them whenever the DUT outputs change.
module tb_aclk_keypad_scanner;

    localparam logic [3:0] NOKEY = 4'hA;

    // Switch indices: row*3 + col.
    localparam int K1 = 0;
    localparam int K3 = 2;
    localparam int K5 = 4;
    localparam int K7 = 6;
    localparam int K9 = 8;
    localparam int KSTAR = 9;
    localparam int KHASH = 11;

    logic       clock;
    logic       reset;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key;
    logic       time_button;
    logic       alarm_button;
    logic       key_press;

    logic [11:0] pressed;
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic        mon_en;
    logic [6:0]  prev_out;
    logic [6:0]  cur_out;

    typedef struct {
        int         cyc;
        logic [3:0] key;
        logic       tbtn;
        logic       abtn;
        logic       kp;
    } evt_t;

    evt_t exp_q[$];

    aclk_keypad_scanner #(
        .SCAN_DIV       (2),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .col_n        (col_n),
        .row_n        (row_n),
        .key          (key),
        .time_button  (time_button),
        .alarm_button (alarm_button),
        .key_press    (key_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle index: 0 is the cycle after the last edge that sampled reset.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Passive switch matrix: a pressed switch pulls its column low while its row is driven low.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < 3; c++) begin
                    if (pressed[r*3 + c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] k, input logic t, input logic a, input logic p);
        evt_t e;
        e.cyc  = c;
        e.key  = k;
        e.tbtn = t;
        e.abtn = a;
        e.kp   = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        @(negedge clock);
        while (cyc != target && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (cyc != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cycle: reached %0d, wanted %0d", cyc, target);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every change of the output bundle must match the next queued expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            cur_out = {key, time_button, alarm_button, key_press};
            if (cur_out !== prev_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d key=%h time=%b alarm=%b press=%b, expected no change",
                             cyc, key, time_button, alarm_button, key_press);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    check("evt_cycle", cyc, e.cyc);
                    check("evt_key", key, e.key);
                    check("evt_time_button", time_button, e.tbtn);
                    check("evt_alarm_button", alarm_button, e.abtn);
                    check("evt_key_press", key_press, e.kp);
                    check("evt_one_hot", ($countones({key != NOKEY, time_button, alarm_button}) <= 1), 1);
                end
            end
            prev_out = cur_out;
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] walk [8];
        walk = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        pressed  = '0;
        prev_out = '0;

        // 1. Reset state and row walk
        do_reset();
        check("reset_key", key, NOKEY);
        check("reset_time_button", time_button, 1'b0);
        check("reset_alarm_button", alarm_button, 1'b0);
        check("reset_key_press", key_press, 1'b0);
        prev_out = {key, time_button, alarm_button, key_press};
        mon_en   = 1'b1;
        check("row_walk", row_n, walk[0]);
        for (int i = 1; i < 8; i++) begin
            @(negedge clock);
            check("row_walk", row_n, walk[i]);
        end

        // 2. Steady '5': press at scan 2, accepted after scan 4; release at scan 6, dropped after scan 8
        wait_until(16);
        pressed[K5] = 1'b1;
        push(40, 4'd5, 1'b0, 1'b0, 1'b1);
        push(41, 4'd5, 1'b0, 1'b0, 1'b0);
        wait_until(48);
        pressed[K5] = 1'b0;
        push(72, NOKEY, 1'b0, 1'b0, 1'b0);

        // 3. '7' on alternate scans only: never accepted
        for (int s = 10; s < 16; s += 2) begin
            wait_until(s * 8);
            pressed[K7] = 1'b1;
            wait_until(s * 8 + 8);
            pressed[K7] = 1'b0;
        end

        // 4. '1' and '9' together: ghost-rejected
        wait_until(136);
        pressed[K1] = 1'b1;
        pressed[K9] = 1'b1;
        wait_until(170);
        check("ghost_key", key, NOKEY);
        check("ghost_buttons", {time_button, alarm_button}, 2'b00);
        wait_until(176);
        pressed[K1] = 1'b0;
        pressed[K9] = 1'b0;

        // 5. '*' then '#'
        wait_until(192);
        pressed[KSTAR] = 1'b1;
        push(216, NOKEY, 1'b1, 1'b0, 1'b1);
        push(217, NOKEY, 1'b1, 1'b0, 1'b0);
        wait_until(224);
        pressed[KSTAR] = 1'b0;
        push(248, NOKEY, 1'b0, 1'b0, 1'b0);
        wait_until(256);
        pressed[KHASH] = 1'b1;
        push(280, NOKEY, 1'b0, 1'b1, 1'b1);
        push(281, NOKEY, 1'b0, 1'b1, 1'b0);
        wait_until(288);
        pressed[KHASH] = 1'b0;
        push(312, NOKEY, 1'b0, 1'b0, 1'b0);

        // 6. '3' held, one-scan dropout absorbed, then reset while still held
        wait_until(320);
        pressed[K3] = 1'b1;
        push(344, 4'd3, 1'b0, 1'b0, 1'b1);
        push(345, 4'd3, 1'b0, 1'b0, 1'b0);
        wait_until(360);
        pressed[K3] = 1'b0;
        wait_until(368);
        pressed[K3] = 1'b1;
        wait_until(400);
        push(0, NOKEY, 1'b0, 1'b0, 1'b0);
        push(24, 4'd3, 1'b0, 1'b0, 1'b1);
        push(25, 4'd3, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_until(40);
        pressed[K3] = 1'b0;
        push(64, NOKEY, 1'b0, 1'b0, 1'b0);
        wait_until(80);

        check("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
